// File: rtl/uart_defs_pkg.sv
// Definitions shared by the UART transmitter and receiver.
// Holds the common FSM encoding and the bit-period derivation.
package uart_defs_pkg;

    // Same encoding as uart_tx, so both ends decode the same state numbers.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin, followed by a delay
// flop so that a registered falling edge can be detected.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic synced,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic delay_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= RESET_VALUE;
            sync_q  <= RESET_VALUE;
            delay_q <= RESET_VALUE;
        end else begin
            meta    <= rxd;
            sync_q  <= meta;
            delay_q <= sync_q;
        end
    end

    assign synced = sync_q;
    assign fall   = delay_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, mid-bit sampling of an LSB-first
// payload and one-cycle strobes for good words, framing errors and breaks.
module uart_rx
    import uart_defs_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uartbusy,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int COUNT_REG_LEN  = 1 + $clog2(CYCLES_PER_BIT);

    localparam logic [COUNT_REG_LEN-1:0] BIT_END  = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
    localparam logic [COUNT_REG_LEN-1:0] HALF_END = COUNT_REG_LEN'(HALF_BIT - 1);
    localparam logic [COUNT_REG_LEN-1:0] CNT_ONE  = COUNT_REG_LEN'(1);
    localparam logic [3:0]               LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]               LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_t             state;
    logic [COUNT_REG_LEN-1:0] cycle_counter;
    logic [3:0]              bit_counter;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS-1:0] shift_next;
    logic                    stop_err;
    logic                    first_stop_low;

    logic synced;
    logic fall;
    logic half_done;
    logic bit_done;
    logic stop_err_next;
    logic first_low_final;

    uart_rx_sync #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .rxd    (uart_rxd),
        .synced (synced),
        .fall   (fall)
    );

    // New samples enter at the MSB so the first data bit ends up in bit 0.
    always_comb begin
        shift_next = shift_reg >> 1;
        shift_next[PAYLOAD_BITS-1] = synced;
    end

    assign half_done       = (cycle_counter == HALF_END);
    assign bit_done        = (cycle_counter == BIT_END);
    assign stop_err_next   = stop_err | ~synced;
    assign first_low_final = (bit_counter == 4'd0) ? ~synced : first_stop_low;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cycle_counter     <= '0;
            bit_counter       <= '0;
            shift_reg         <= '0;
            stop_err          <= 1'b0;
            first_stop_low    <= 1'b0;
            uartbusy          <= 1'b0;
            uart_rx_valid     <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;

            case (state)
                IDLE: begin
                    cycle_counter  <= '0;
                    bit_counter    <= '0;
                    stop_err       <= 1'b0;
                    first_stop_low <= 1'b0;
                    // Only an edge starts a frame, so a stuck-low line cannot retrigger.
                    if (fall && uart_rx_en) begin
                        state    <= START;
                        uartbusy <= 1'b1;
                    end
                end

                START: begin
                    if (half_done) begin
                        cycle_counter <= '0;
                        if (!synced) begin
                            state <= RECV;
                        end else begin
                            state    <= IDLE;
                            uartbusy <= 1'b0;
                        end
                    end else begin
                        cycle_counter <= cycle_counter + CNT_ONE;
                    end
                end

                RECV: begin
                    if (bit_done) begin
                        cycle_counter <= '0;
                        shift_reg     <= shift_next;
                        if (bit_counter == LAST_DATA) begin
                            bit_counter <= '0;
                            state       <= STOP;
                        end else begin
                            bit_counter <= bit_counter + 4'd1;
                        end
                    end else begin
                        cycle_counter <= cycle_counter + CNT_ONE;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        cycle_counter <= '0;
                        stop_err      <= stop_err_next;
                        if (bit_counter == 4'd0) begin
                            first_stop_low <= ~synced;
                        end
                        // Leaving STOP and strobing share one edge, so a start
                        // edge inside the last half stop bit is still caught.
                        if (bit_counter == LAST_STOP) begin
                            bit_counter <= '0;
                            state       <= IDLE;
                            uartbusy    <= 1'b0;
                            if (!stop_err_next) begin
                                uart_rx_valid <= 1'b1;
                                uart_rx_data  <= shift_reg;
                            end else if (first_low_final && (shift_reg == '0)) begin
                                uart_rx_break <= 1'b1;
                            end else begin
                                uart_rx_frame_err <= 1'b1;
                            end
                        end else begin
                            bit_counter <= bit_counter + 4'd1;
                        end
                    end else begin
                        cycle_counter <= cycle_counter + CNT_ONE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    uartbusy      <= 1'b0;
                    cycle_counter <= '0;
                    bit_counter   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: good frames, glitches,
// framing errors, breaks, back-to-back frames and mid-frame reset.
module tb_uart_rx;

    localparam int CLK_HZ       = 1_000_000;
    localparam int BIT_RATE     = 100_000;
    localparam int PAYLOAD_BITS = 8;
    localparam int STOP_BITS    = 1;
    localparam int CPB          = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uartbusy;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int valid_count = 0;
    int ferr_count = 0;
    int break_count = 0;
    int busy_cycles = 0;
    int last_valid_cycle = 0;
    int start_cycle = 0;
    logic [7:0] rx_words[$];

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uartbusy          (uartbusy),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe observer on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (uart_rx_valid) begin
            valid_count++;
            last_valid_cycle = cyc;
            rx_words.push_back(uart_rx_data);
        end
        if (uart_rx_frame_err) ferr_count++;
        if (uart_rx_break) break_count++;
        if (uartbusy) busy_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        valid_count = 0;
        ferr_count  = 0;
        break_count = 0;
        busy_cycles = 0;
        rx_words.delete();
    endtask

    task automatic holdLine(input logic level, input int cycles);
        uart_rxd = level;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Serialises one frame; entered and left 1 time unit after a clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_level);
        start_cycle = cyc;
        holdLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdLine(data[i], CPB);
        holdLine(stop_level, CPB);
    endtask

    initial begin
        $display("[TB] uart_rx directed test start");
        reset = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", uartbusy, 0);
        checkOutput("reset_valid", uart_rx_valid, 0);
        checkOutput("reset_frame_err", uart_rx_frame_err, 0);
        checkOutput("reset_break", uart_rx_break, 0);
        checkOutput("reset_data", uart_rx_data, 8'h00);

        // Good frame and pin-to-valid latency.
        clearCounts();
        applyStimulus(8'hA5, 1'b1);
        holdLine(1'b1, 20);
        checkOutput("a5_valid_count", valid_count, 1);
        checkOutput("a5_data", uart_rx_data, 8'hA5);
        checkOutput("a5_frame_err", ferr_count, 0);
        checkOutput("a5_break", break_count, 0);
        checkOutput("a5_latency", last_valid_cycle - start_cycle, 98);
        checkOutput("a5_busy_after", uartbusy, 0);

        // Three-cycle low glitch: start detected, rejected at half bit.
        clearCounts();
        holdLine(1'b0, 3);
        holdLine(1'b1, 30);
        checkOutput("glitch_strobes", valid_count + ferr_count + break_count, 0);
        checkOutput("glitch_busy_cycles", busy_cycles, 5);
        checkOutput("glitch_busy_after", uartbusy, 0);

        // Stop bit driven low on a non-zero word.
        clearCounts();
        applyStimulus(8'h3C, 1'b0);
        holdLine(1'b1, 30);
        checkOutput("ferr_count", ferr_count, 1);
        checkOutput("ferr_valid", valid_count, 0);
        checkOutput("ferr_break", break_count, 0);
        checkOutput("ferr_data_held", uart_rx_data, 8'hA5);

        // Line held low: a single break, no retrigger while it stays low.
        clearCounts();
        holdLine(1'b0, 200);
        holdLine(1'b1, 30);
        checkOutput("break_count", break_count, 1);
        checkOutput("break_frame_err", ferr_count, 0);
        checkOutput("break_valid", valid_count, 0);
        checkOutput("break_data_held", uart_rx_data, 8'hA5);

        // Back-to-back frames as a transmitter would emit them.
        clearCounts();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h55, 1'b1);
        holdLine(1'b1, 20);
        checkOutput("loop_valid_count", valid_count, 3);
        checkOutput("loop_errors", ferr_count + break_count, 0);
        checkOutput("loop_word0", (rx_words.size() > 0) ? rx_words[0] : 8'hXX, 8'h00);
        checkOutput("loop_word1", (rx_words.size() > 1) ? rx_words[1] : 8'hXX, 8'hFF);
        checkOutput("loop_word2", (rx_words.size() > 2) ? rx_words[2] : 8'hXX, 8'h55);

        // Reset while bit 4 of 0xF0 is on the line.
        clearCounts();
        holdLine(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdLine(1'b0, CPB);
        holdLine(1'b1, 5);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        holdLine(1'b1, 150);
        checkOutput("rst_strobes", valid_count + ferr_count + break_count, 0);
        checkOutput("rst_data", uart_rx_data, 8'h00);
        checkOutput("rst_busy", uartbusy, 0);

        clearCounts();
        applyStimulus(8'h81, 1'b1);
        holdLine(1'b1, 20);
        checkOutput("post_rst_valid_count", valid_count, 1);
        checkOutput("post_rst_data", uart_rx_data, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
